byte_serializer: RTL and testbench
==================================

# byte_serializer

Parallel-to-serial stage that feeds the `dich` shift register's serial `DIN` input. It accepts an 8-bit word on a single-cycle load strobe and shifts it out MSB-first on `DOUT`, holding each bit for a programmable number of clock cycles. It reports progress with a `BUSY` level and a one-cycle `DONE` pulse. A loaded byte appears on the downstream `LED[7:0]` once the shift register has clocked it in.

## Interface
- `WIDTH`, default 8: data word width in bits; must be ≥ 2.
- `DIV`, default 1: clock cycles each bit is held on `DOUT`; must be ≥ 1.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rs`  in  1: reset, asynchronous, active-high.
- `DATA`  in  WIDTH: word to serialize; sampled only on an accepted load.
- `LOAD`  in  1: load strobe; accepted when the state is IDLE.
- `DOUT`  out  1: serial data to the downstream `DIN`.
- `BUSY`  out  1: high while a frame is being shifted out.
- `DONE`  out  1: one-cycle pulse at frame completion.

## Operation
- Reset value of every output while `rs`=1, and immediately on assertion: `DOUT`=0, `BUSY`=0, `DONE`=0.
- Reset value of all internal state: state=IDLE, bit counter=0, divider counter=0, shift register=0.
- States: IDLE, SHIFT, PAR (the PAR state exists only with `PARITY_EN`).
- IDLE:
  - `DOUT`=0 and `BUSY`=0.
  - If `LOAD`=1 at a clock edge, the block latches `DATA` into the shift register, clears both counters and moves to SHIFT.
- SHIFT:
  - `DOUT` = MSB of the shift register.
  - The divider counter counts 0..DIV-1.
  - At the edge where it reaches DIV-1 it wraps to 0, the shift register shifts left by one (0 fills the LSB), and the bit counter increments.
  - When the bit counter goes from WIDTH-1 to WIDTH at that edge, the next state is PAR if `PARITY_EN` is defined, otherwise IDLE.
- PAR:
  - `DOUT` = XOR of the latched word, i.e. even parity.
  - Held for DIV cycles, then the next state is IDLE.
- `DONE` is registered. It is 1 exactly in the first cycle after the frame's last bit period ends, which is the first cycle back in IDLE.
- `BUSY` is registered, 1 in SHIFT and PAR.
- `LOAD` while BUSY=1 is ignored. It is not queued and `DATA` is not sampled.
- `LOAD` in the `DONE` cycle is accepted, because the state is IDLE. Back-to-back frames therefore have exactly one idle cycle (`DOUT`=0) between them.
- `DATA` changes after the load edge have no effect on the frame in progress.
- Reset mid-frame:
  - Outputs and state go to their reset values immediately.
  - No `DONE` is generated for the aborted frame.
  - After `rs` deasserts, the first `LOAD` starts a fresh frame.

## Timing
- Load edge at cycle T. From cycle T+1, `DOUT`=DATA[WIDTH-1] and `BUSY`=1.
- Bit k (k=0 is the MSB) is on `DOUT` during cycles T+1+k·DIV through T+(k+1)·DIV.
- Without parity, frame length is WIDTH·DIV cycles. `DONE`=1 and `BUSY`=0 at cycle T+1+WIDTH·DIV.
- With parity, frame length is (WIDTH+1)·DIV cycles. `DONE` is at cycle T+1+(WIDTH+1)·DIV.
- The bit counter is ⌈log2(WIDTH+1)⌉ bits and the divider counter is ⌈log2(DIV)⌉ bits, minimum 1 bit each. Neither counter wraps during a frame.
- `DOUT` changes only at rising edges, so the downstream stage, clocked on the same `clk`, samples each bit DIV times. With DIV=1 it captures each bit exactly once.

## Configuration
- `BYTE_SERIALIZER_PARITY_EN` defined:
  - The PAR state is compiled in.
  - An even-parity bit follows the data bits and is held for DIV cycles.
  - The frame is WIDTH+1 bits.
- Macro undefined:
  - No PAR state and no parity logic.
  - The frame is exactly WIDTH bits.
  - After the last data bit the next state is IDLE.

## Test plan
- Reset: assert `rs` for 20 ns mid-idle, then drive `LOAD`=1 during reset → `DOUT`=0, `BUSY`=0, `DONE`=0 throughout; no frame starts.
- Basic frame, DIV=1, no parity: `DATA`=8'hA5, load at cycle T → `DOUT` shows 1,0,1,0,0,1,0,1 in cycles T+1..T+8. `DONE` pulses in cycle T+9. Downstream `LED` = 8'hA5.
- DIV=3: `DATA`=8'h81 → `DOUT`=1 for 3 cycles, 0 for 18 cycles, then 1 for 3 cycles. `BUSY` is high for 24 cycles.
- Ignored load: `DATA`=8'hF0 loaded, then `LOAD` with `DATA`=8'h0F at cycle T+4 → the output remains the 8'hF0 pattern and only one `DONE` pulse occurs.
- Back-to-back: `LOAD` held high with 8'h3C then 8'hC3 → second frame starts the cycle after `DONE`, with one `DOUT`=0 gap cycle.
- With `BYTE_SERIALIZER_PARITY_EN` defined:
  - 8'h07 → ninth bit = 1, `DONE` at T+10.
  - Separately, reset asserted at bit 5 of 8'hFF → `DOUT`=0 immediately and no `DONE`.

Source files
------------

// File: rtl/byte_serializer.sv
// byte_serializer: MSB-first parallel-to-serial stage, each bit held DIV cycles.
// Define BYTE_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module byte_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV = 1
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LOAD,
  output logic             DOUT,
  output logic             BUSY,
  output logic             DONE
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
`ifdef BYTE_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state, state_n;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [WIDTH-1:0] sreg;
  logic wrap, last;
  assign wrap = div_cnt == DW'(DIV - 1);
  assign last = bit_cnt == BW'(WIDTH - 1);
`ifdef BYTE_SERIALIZER_PARITY_EN
  // parity is captured at load because sreg is consumed while shifting
  logic par;
  always_ff @(posedge clk or posedge rs)
    if (rs) par <= 1'b0;
    else if (state == IDLE && LOAD) par <= ^DATA;
  assign DOUT = state == SHIFT ? sreg[WIDTH-1] : state == PAR && par;
  always_comb begin
    state_n = state;
    if (state == IDLE && LOAD) state_n = SHIFT;
    else if (state == SHIFT && wrap && last) state_n = PAR;
    else if (state == PAR && wrap) state_n = IDLE;
  end
`else
  assign DOUT = state == SHIFT && sreg[WIDTH-1];
  always_comb begin
    state_n = state;
    if (state == IDLE && LOAD) state_n = SHIFT;
    else if (state == SHIFT && wrap && last) state_n = IDLE;
  end
`endif
  always_ff @(posedge clk or posedge rs)
    if (rs) begin
      state   <= IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      sreg    <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      state <= state_n;
      BUSY  <= state_n != IDLE;
      DONE  <= state != IDLE && state_n == IDLE;
      if (state == IDLE) begin
        if (LOAD) begin
          sreg    <= DATA;
          bit_cnt <= '0;
          div_cnt <= '0;
        end
      end else begin
        div_cnt <= wrap ? '0 : div_cnt + 1'b1;
        if (state == SHIFT && wrap) begin
          sreg    <= {sreg[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: drives DIV=1 and DIV=3 instances with shared stimulus and
// compares every cycle against a frame-timing model built from load times.
module tb_byte_serializer;
`ifdef BYTE_SERIALIZER_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif
  localparam int W = 8;
  logic clk = 0, rs = 0, load = 0;
  logic [7:0] data = 0;
  logic d0, b0, n0, d1, b1, n1;
  logic [1:0][2:0] obs;
  int cyc = 0, checks = 0, errors = 0;
  int dv[2] = '{1, 3};
  int tl[2];
  logic [7:0] td[2];
  logic act[2];
  logic [7:0] led;

  always #5 clk = ~clk;

  byte_serializer #(.WIDTH(8), .DIV(1)) u1 (.clk(clk), .rs(rs), .DATA(data), .LOAD(load), .DOUT(d0), .BUSY(b0), .DONE(n0));
  byte_serializer #(.WIDTH(8), .DIV(3)) u3 (.clk(clk), .rs(rs), .DATA(data), .LOAD(load), .DOUT(d1), .BUSY(b1), .DONE(n1));

  assign obs[0] = {d0, b0, n0};
  assign obs[1] = {d1, b1, n1};

  // downstream shift register fed by the DIV=1 instance
  always @(posedge clk) begin
    cyc <= cyc + 1;
    led <= {led[6:0], d0};
  end

  // reference: a frame is the load cycle plus FB*DIV bit cycles; loads only land when idle
  always @(posedge clk or posedge rs)
    if (rs) begin
      act[0] <= 1'b0;
      act[1] <= 1'b0;
    end else
      for (int i = 0; i < 2; i++)
        if (load && (!act[i] || cyc - tl[i] > FB * dv[i])) begin
          act[i] <= 1'b1;
          tl[i]  <= cyc;
          td[i]  <= data;
        end

  function automatic logic [2:0] expect_out(input int i);
    int len, d, k;
    len = FB * dv[i];
    d = cyc - tl[i];
    if (rs || !act[i]) return 3'b000;
    if (d >= 1 && d <= len) begin
      k = (d - 1) / dv[i];
      return {(k < W) ? td[i][W-1-k] : ^td[i], 2'b10};
    end
    return {2'b00, d == len + 1};
  endfunction

  task automatic test_reset();
    load = 1;
    data = $urandom;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== 3'b000) begin errors++; $display("FAIL reset_hold dut%0d got=%b exp=000", i, obs[i]); end
      end
    end
    rs = 0;
    load = 0;
    repeat (3) @(negedge clk);
    #2 rs = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 3'b000) begin errors++; $display("FAIL reset_idle dut%0d got=%b exp=000", i, obs[i]); end
    end
    @(negedge clk);
    load = 1;
    data = $urandom;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 3'b000) begin errors++; $display("FAIL reset_load dut%0d got=%b exp=000", i, obs[i]); end
    end
    rs = 0;
    load = 0;
    repeat (6) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== 3'b000) begin errors++; $display("FAIL reset_nostart dut%0d got=%b exp=000", i, obs[i]); end
      end
    end
  endtask

  task automatic test_basic(input logic [7:0] v, input string name);
    int t, dones;
    logic [7:0] lv;
    lv = v;
    dones = 0;
    @(negedge clk);
    t = cyc;
    data = v;
    load = 1;
    repeat (FB * 3 + 6) begin
      @(negedge clk);
      load = 0;
      data = $urandom;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== expect_out(i)) begin errors++; $display("FAIL %s dut%0d cyc=%0d got=%b exp=%b", name, i, cyc, obs[i], expect_out(i)); end
      end
      if (n0) begin
        dones++;
        checks += 2;
        if (cyc !== t + FB + 1) begin errors++; $display("FAIL %s_done_cycle got=%0d exp=%0d", name, cyc - t, FB + 1); end
        if (led !== (FB == 8 ? lv : {lv[6:0], ^lv})) begin errors++; $display("FAIL %s_led got=%h exp=%h", name, led, FB == 8 ? lv : {lv[6:0], ^lv}); end
      end
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL %s_done_count got=%0d exp=1", name, dones); end
  endtask

  task automatic test_div();
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    data = 8'h81;
    load = 1;
    repeat (FB * 3 + 6) begin
      @(negedge clk);
      load = 0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== expect_out(i)) begin errors++; $display("FAIL div dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs[i], expect_out(i)); end
      end
      if (b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != FB * 3) begin errors++; $display("FAIL div_busy_len got=%0d exp=%0d", busy_cnt, FB * 3); end
  endtask

  task automatic test_ignored_load();
    int dn0, dn1;
    dn0 = 0;
    dn1 = 0;
    @(negedge clk);
    data = 8'hF0;
    load = 1;
    for (int c = 1; c < FB * 3 + 6; c++) begin
      @(negedge clk);
      load = c == 4;
      data = c == 4 ? 8'h0F : data;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== expect_out(i)) begin errors++; $display("FAIL ignored dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs[i], expect_out(i)); end
      end
      dn0 += int'(n0);
      dn1 += int'(n1);
    end
    checks += 2;
    if (dn0 != 1) begin errors++; $display("FAIL ignored_done dut0 got=%0d exp=1", dn0); end
    if (dn1 != 1) begin errors++; $display("FAIL ignored_done dut1 got=%0d exp=1", dn1); end
  endtask

  task automatic test_back_to_back();
    int dn0;
    dn0 = 0;
    @(negedge clk);
    data = 8'h3C;
    load = 1;
    for (int c = 0; c < FB * 6 + 12; c++) begin
      @(negedge clk);
      data = 8'hC3;
      load = c < FB * 3 + 4;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== expect_out(i)) begin errors++; $display("FAIL b2b dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs[i], expect_out(i)); end
      end
      if (n0) begin
        dn0++;
        checks++;
        if (d0 !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b exp=0", d0); end
      end
    end
    checks++;
    if (dn0 < 2) begin errors++; $display("FAIL b2b_frames got=%0d exp>=2", dn0); end
  endtask

  task automatic test_random();
    repeat (400) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== expect_out(i)) begin errors++; $display("FAIL random dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs[i], expect_out(i)); end
      end
      load = $urandom_range(0, 3) == 0;
      data = $urandom;
    end
    load = 0;
    repeat (FB * 3 + 4) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int dn;
    dn = 0;
    @(negedge clk);
    data = 8'hFF;
    load = 1;
    repeat (6) begin
      @(negedge clk);
      load = 0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== expect_out(i)) begin errors++; $display("FAIL midrst_pre dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs[i], expect_out(i)); end
      end
    end
    #2 rs = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs[i] !== 3'b000) begin errors++; $display("FAIL midrst_now dut%0d got=%b exp=000", i, obs[i]); end
    end
    @(negedge clk);
    rs = 0;
    repeat (FB * 3 + 4) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== expect_out(i)) begin errors++; $display("FAIL midrst_after dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs[i], expect_out(i)); end
      end
      dn += int'(n0) + int'(n1);
    end
    checks++;
    if (dn != 0) begin errors++; $display("FAIL midrst_nodone got=%0d exp=0", dn); end
  endtask

  initial begin
    rs = 1;
    test_reset();
    test_basic(8'hA5, "basic");
    test_div();
    test_ignored_load();
    test_back_to_back();
    test_basic(8'h07, "parity_word");
    test_random();
    test_reset_midframe();
    test_basic(8'($urandom), "fresh");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
